// File: rtl/editor_celula_sudoku_pkg.sv
// Shared types and constants for the Sudoku cell editor: FSM state encoding,
// board geometry and derived counter widths.
package editor_pkg;

    localparam int TAM_DEF = 9;
    localparam int N_DEF   = 4;
    localparam int W_POS   = $clog2(TAM_DEF);
    localparam int W_IDX   = $clog2(TAM_DEF * TAM_DEF);
    localparam logic [N_DEF-1:0] VAZIO = '0;

    typedef enum logic [1:0] {
        NAVEGA = 2'd0,
        EDITA  = 2'd1,
        GRAVA  = 2'd2
    } estado_t;

endpackage

// File: rtl/editor_celula_sudoku_if.sv
// Button inputs, cell-status inputs and cursor/write outputs of the cell editor.
// The master side is the panel or bench; the slave side is the editor.
interface editor_if #(
    parameter int N     = editor_pkg::N_DEF,
    parameter int W_POS = editor_pkg::W_POS,
    parameter int W_IDX = editor_pkg::W_IDX
);
    logic             btn_cima;
    logic             btn_baixo;
    logic             btn_esq;
    logic             btn_dir;
    logic             btn_valor;
    logic             btn_confirma;
    logic             btn_cancela;
    logic [N-1:0]     valor_atual;
    logic             celula_fixa;
    logic [W_POS-1:0] linha;
    logic [W_POS-1:0] coluna;
    logic [W_IDX-1:0] indice;
    logic             we;
    logic [N-1:0]     dado;
    logic             editando;
    logic [N-1:0]     valor_edicao;

    modport master (
        output btn_cima, btn_baixo, btn_esq, btn_dir, btn_valor,
               btn_confirma, btn_cancela, valor_atual, celula_fixa,
        input  linha, coluna, indice, we, dado, editando, valor_edicao
    );

    modport slave (
        input  btn_cima, btn_baixo, btn_esq, btn_dir, btn_valor,
               btn_confirma, btn_cancela, valor_atual, celula_fixa,
        output linha, coluna, indice, we, dado, editando, valor_edicao
    );
endinterface

// File: rtl/editor_celula_sudoku_contador_mod.sv
// Modulo-TAM up/down counter with wrap-around on both ends; used for the
// cursor row and column.
module contador_mod #(
    parameter int TAM = 9,
    parameter int W   = $clog2(TAM)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] valor
);
    logic [W-1:0] valor_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valor_reg <= '0;
        end else if (inc) begin
            valor_reg <= (valor_reg == W'(TAM - 1)) ? '0 : valor_reg + 1'b1;
        end else if (dec) begin
            valor_reg <= (valor_reg == '0) ? W'(TAM - 1) : valor_reg - 1'b1;
        end
    end

    assign valor = valor_reg;
endmodule

// File: rtl/editor_celula_sudoku.sv
// Sudoku cell editor: cursor navigation, value-edit session and one-cycle write
// strobe. Define EDITOR_AUTO_AVANCO_EN to advance the cursor after each write.
module editor_celula_sudoku
    import editor_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int TAM   = TAM_DEF,
    parameter int W_POS = $clog2(TAM),
    parameter int W_IDX = $clog2(TAM * TAM)
) (
    input  logic     clk,
    input  logic     rst,
    editor_if.slave  bus
);
    estado_t          estado_reg, estado_next;
    logic [N-1:0]     valor_edicao_reg, valor_edicao_next;
    logic [N-1:0]     dado_reg, dado_next;
    logic             linha_inc, linha_dec, coluna_inc, coluna_dec;
    logic [W_POS-1:0] linha, coluna;

    contador_mod #(.TAM(TAM), .W(W_POS)) u_linha (
        .clk(clk), .rst(rst), .inc(linha_inc), .dec(linha_dec), .valor(linha)
    );

    contador_mod #(.TAM(TAM), .W(W_POS)) u_coluna (
        .clk(clk), .rst(rst), .inc(coluna_inc), .dec(coluna_dec), .valor(coluna)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg       <= NAVEGA;
            valor_edicao_reg <= N'(VAZIO);
            dado_reg         <= '0;
        end else begin
            estado_reg       <= estado_next;
            valor_edicao_reg <= valor_edicao_next;
            dado_reg         <= dado_next;
        end
    end

    always_comb begin
        estado_next       = estado_reg;
        valor_edicao_next = valor_edicao_reg;
        dado_next         = dado_reg;
        linha_inc         = 1'b0;
        linha_dec         = 1'b0;
        coluna_inc        = 1'b0;
        coluna_dec        = 1'b0;
        unique case (estado_reg)
            NAVEGA: begin
                if (bus.btn_confirma && !bus.celula_fixa) begin
                    valor_edicao_next = bus.valor_atual;
                    estado_next       = EDITA;
                end else if (bus.btn_cima) begin
                    linha_dec = 1'b1;
                end else if (bus.btn_baixo) begin
                    linha_inc = 1'b1;
                end else if (bus.btn_esq) begin
                    coluna_dec = 1'b1;
                end else if (bus.btn_dir) begin
                    coluna_inc = 1'b1;
                end
            end
            EDITA: begin
                if (bus.btn_cancela) begin
                    estado_next = NAVEGA;
                end else if (bus.btn_confirma) begin
                    // Latch the data one edge early so dado is stable for the whole GRAVA cycle.
                    dado_next   = valor_edicao_reg;
                    estado_next = GRAVA;
                end else if (bus.btn_valor) begin
                    valor_edicao_next = (valor_edicao_reg == N'(TAM)) ? '0 : valor_edicao_reg + 1'b1;
                end
            end
            GRAVA: begin
                estado_next = NAVEGA;
`ifdef EDITOR_AUTO_AVANCO_EN
                coluna_inc = 1'b1;
                linha_inc  = (coluna == W_POS'(TAM - 1));
`endif
            end
            default: estado_next = NAVEGA;
        endcase
    end

    assign bus.linha        = linha;
    assign bus.coluna       = coluna;
    assign bus.indice       = W_IDX'(linha * TAM + coluna);
    assign bus.we           = (estado_reg == GRAVA);
    assign bus.dado         = dado_reg;
    assign bus.editando     = (estado_reg == EDITA);
    assign bus.valor_edicao = valor_edicao_reg;
endmodule

// File: tb/tb_editor_celula_sudoku.sv
// Directed, table-driven bench for editor_celula_sudoku: one vector per clock,
// plus hand sequences for reset-in-edit, simultaneous moves and commit at cell 80.
module tb_editor_celula_sudoku;
    localparam int N = 4;
`ifdef EDITOR_AUTO_AVANCO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    // Button bit positions: {cima, baixo, esq, dir, valor, confirma, cancela}
    localparam logic [6:0] B_NONE = 7'b0000000;
    localparam logic [6:0] B_CIMA = 7'b1000000;
    localparam logic [6:0] B_BAIX = 7'b0100000;
    localparam logic [6:0] B_ESQ  = 7'b0010000;
    localparam logic [6:0] B_DIR  = 7'b0001000;
    localparam logic [6:0] B_VAL  = 7'b0000100;
    localparam logic [6:0] B_CONF = 7'b0000010;
    localparam logic [6:0] B_CANC = 7'b0000001;

    typedef struct {
        logic [6:0] btn;
        logic [3:0] va;
        logic       fixa;
        int         l, c, idx, we, dado, ed, ve;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    editor_if #(.N(N), .W_POS(4), .W_IDX(7)) ifc ();

    editor_celula_sudoku dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] b, input logic [3:0] va, input logic fixa);
        {ifc.btn_cima, ifc.btn_baixo, ifc.btn_esq, ifc.btn_dir,
         ifc.btn_valor, ifc.btn_confirma, ifc.btn_cancela} = b;
        ifc.valor_atual = va;
        ifc.celula_fixa = fixa;
        @(posedge clk);
        #1;
        {ifc.btn_cima, ifc.btn_baixo, ifc.btn_esq, ifc.btn_dir,
         ifc.btn_valor, ifc.btn_confirma, ifc.btn_cancela} = B_NONE;
    endtask

    task automatic add(input logic [6:0] b, input logic [3:0] va, input logic fixa,
                       input int l, input int c, input int we, input int dado,
                       input int ed, input int ve);
        vec_t v;
        v.btn = b; v.va = va; v.fixa = fixa;
        v.l = l; v.c = c; v.idx = l * 9 + c; v.we = we; v.dado = dado; v.ed = ed; v.ve = ve;
        tab.push_back(v);
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, " linha"}, int'(ifc.linha), v.l);
        chk({tag, " coluna"}, int'(ifc.coluna), v.c);
        chk({tag, " indice"}, int'(ifc.indice), v.idx);
        chk({tag, " we"}, int'(ifc.we), v.we);
        chk({tag, " dado"}, int'(ifc.dado), v.dado);
        chk({tag, " editando"}, int'(ifc.editando), v.ed);
        chk({tag, " valor_edicao"}, int'(ifc.valor_edicao), v.ve);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(B_NONE, 4'd0, 1'b0);
        drive(B_NONE, 4'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int  ca;
        vec_t e;
        ca = AUTO ? 4 : 3;
        // Navigation with wrap-around
        add(B_ESQ,  0, 0, 0, 8, 0, 0, 0, 0);
        add(B_CIMA, 0, 0, 8, 8, 0, 0, 0, 0);
        add(B_DIR,  0, 0, 8, 0, 0, 0, 0, 0);
        add(B_BAIX, 0, 0, 0, 0, 0, 0, 0, 0);
        add(B_BAIX, 0, 0, 1, 0, 0, 0, 0, 0);
        add(B_BAIX, 0, 0, 2, 0, 0, 0, 0, 0);
        add(B_DIR,  0, 0, 2, 1, 0, 0, 0, 0);
        add(B_DIR,  0, 0, 2, 2, 0, 0, 0, 0);
        add(B_DIR,  0, 0, 2, 3, 0, 0, 0, 0);
        // Edit session at (2,3): 5 -> 6,7,8,9,0 then commit
        add(B_CONF | B_DIR, 5, 0, 2, 3, 0, 0, 1, 5);
        add(B_VAL | B_DIR,  0, 0, 2, 3, 0, 0, 1, 6);
        add(B_VAL,  0, 0, 2, 3, 0, 0, 1, 7);
        add(B_VAL,  0, 0, 2, 3, 0, 0, 1, 8);
        add(B_VAL,  0, 0, 2, 3, 0, 0, 1, 9);
        add(B_VAL,  0, 0, 2, 3, 0, 0, 1, 0);
        add(B_CONF | B_VAL, 0, 0, 2, 3, 1, 0, 0, 0);
        add(B_NONE, 0, 0, 2, ca, 0, 0, 0, 0);
        // Fixed cell: confirma ignored
        add(B_CONF, 7, 1, 2, ca, 0, 0, 0, 0);
        add(B_NONE, 7, 1, 2, ca, 0, 0, 0, 0);
        // Cancel wins over confirma, no write
        add(B_CONF, 3, 0, 2, ca, 0, 0, 1, 3);
        add(B_CANC | B_CONF, 0, 0, 2, ca, 0, 0, 0, 3);
        add(B_NONE, 0, 0, 2, ca, 0, 0, 0, 3);

        ifc.valor_atual = '0;
        ifc.celula_fixa = 1'b0;
        do_reset();
        e = '{btn: B_NONE, va: 0, fixa: 0, l: 0, c: 0, idx: 0, we: 0, dado: 0, ed: 0, ve: 0};
        check_out("reset", e);

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].btn, tab[i].va, tab[i].fixa);
            $display("vec %0d btn=%b -> l=%0d c=%0d idx=%0d we=%0d dado=%0d ed=%0d ve=%0d",
                     i, tab[i].btn, ifc.linha, ifc.coluna, ifc.indice, ifc.we,
                     ifc.dado, ifc.editando, ifc.valor_edicao);
            check_out($sformatf("vec%0d", i), tab[i]);
        end

        // Simultaneous cima+dir at (0,0), then reset during EDITA
        do_reset();
        drive(B_CIMA | B_DIR, 0, 0);
        $display("seq cima+dir -> l=%0d c=%0d", ifc.linha, ifc.coluna);
        chk("cima+dir linha", int'(ifc.linha), 8);
        chk("cima+dir coluna", int'(ifc.coluna), 0);
        drive(B_CONF, 2, 0);
        chk("edit entered", int'(ifc.editando), 1);
        rst = 1'b1;
        drive(B_CONF, 2, 0);
        rst = 1'b0;
        $display("seq rst in EDITA -> ed=%0d l=%0d c=%0d we=%0d", ifc.editando, ifc.linha, ifc.coluna, ifc.we);
        chk("rst editando", int'(ifc.editando), 0);
        chk("rst linha", int'(ifc.linha), 0);
        chk("rst coluna", int'(ifc.coluna), 0);
        chk("rst we", int'(ifc.we), 0);
        chk("rst valor_edicao", int'(ifc.valor_edicao), 0);
        drive(B_NONE, 0, 0);
        chk("rst no late we", int'(ifc.we), 0);

        // Commit at cell 80 with value 1
        drive(B_CIMA, 0, 0);
        drive(B_ESQ, 0, 0);
        drive(B_CONF, 0, 0);
        drive(B_VAL, 0, 0);
        chk("c80 valor_edicao", int'(ifc.valor_edicao), 1);
        drive(B_CONF, 0, 0);
        $display("seq commit80 -> we=%0d idx=%0d dado=%0d", ifc.we, ifc.indice, ifc.dado);
        chk("c80 we", int'(ifc.we), 1);
        chk("c80 indice", int'(ifc.indice), 80);
        chk("c80 dado", int'(ifc.dado), 1);
        drive(B_NONE, 0, 0);
        $display("seq after commit80 -> we=%0d l=%0d c=%0d", ifc.we, ifc.linha, ifc.coluna);
        chk("c80 we end", int'(ifc.we), 0);
        chk("c80 dado hold", int'(ifc.dado), 1);
        chk("c80 linha after", int'(ifc.linha), AUTO ? 0 : 8);
        chk("c80 coluna after", int'(ifc.coluna), AUTO ? 0 : 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
